// File: rtl/ble_packet_uart_dump.sv
// ble_packet_uart_dump
//   Snapshots the sniffer's decoded packet on each rising edge of
//   packet_detected and streams the captured PDU bytes over an 8N1 UART
//   line (data bit 0 first, CLK_DIV clk cycles per bit, no idle gap
//   between back-to-back bytes).
//
// Configuration macro: PKT_DUMP_HEADER_EN
//   defined   - each frame is prefixed by 0xA5 and a byte equal to nbytes
//   undefined - payload bytes only
//
// Ports
//   clk             system clock, all logic on posedge
//   rst             synchronous active-high reset
//   packet_detected sniffer detect level; its rising edge is the capture event
//   packet_in       packet bits, [PACKET_BITS-1] is the first received bit
//   packet_len      number of valid bits in packet_in (clamped to PACKET_BITS)
//   uart_tx         serial line, idle high
//   busy            a captured frame is being sent
//   done            one-cycle pulse after the last stop bit
//   dropped_cnt     events ignored while busy, saturating at 255
module ble_packet_uart_dump #(
    parameter int unsigned PACKET_BITS = 368,
    parameter int unsigned LEN_W       = 9,
    parameter int unsigned CLK_DIV     = 139
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   packet_detected,
    input  logic [PACKET_BITS-1:0] packet_in,
    input  logic [LEN_W-1:0]       packet_len,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             dropped_cnt
);

    localparam int unsigned MAX_BYTES = (PACKET_BITS + 7) / 8;
    // Room for header bytes on top of the payload byte index.
    localparam int unsigned BYTE_W    = $clog2(MAX_BYTES + 3);
    localparam int unsigned DIV_W     = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        FIN
    } state_t;

    state_t                 state, state_next;
    logic                   det_q;
    logic                   pkt_event;
    logic [DIV_W-1:0]       bit_tmr;
    logic                   bit_end;
    logic [2:0]             bit_idx;
    logic [BYTE_W-1:0]      byte_idx;
    logic [BYTE_W-1:0]      nbytes_q;
    logic [BYTE_W-1:0]      nbytes_in;
    logic [PACKET_BITS-1:0] shreg;
    logic [7:0]             tx_byte;
    logic                   last_byte;
    logic                   payload_byte;
    logic [31:0]            len_ext;
    logic [31:0]            len_clamp;

    assign pkt_event = packet_detected & ~det_q;
    assign bit_end   = (bit_tmr == DIV_W'(CLK_DIV - 1));

    // Byte count for the capture: ceil(min(packet_len, PACKET_BITS) / 8).
    always_comb begin
        len_ext   = 32'(packet_len);
        len_clamp = (len_ext > PACKET_BITS) ? PACKET_BITS : len_ext;
        nbytes_in = BYTE_W'((len_clamp + 32'd7) >> 3);
    end

    // The payload is held in a shift register whose top byte is always the
    // next payload byte to send; it shifts after each payload byte's stop bit.
`ifdef PKT_DUMP_HEADER_EN
    always_comb begin
        payload_byte = (byte_idx >= BYTE_W'(2));
        last_byte    = (byte_idx == BYTE_W'(nbytes_q + BYTE_W'(1)));
        if (byte_idx == '0) begin
            tx_byte = 8'hA5;
        end else if (byte_idx == BYTE_W'(1)) begin
            tx_byte = 8'(nbytes_q);
        end else begin
            tx_byte = shreg[PACKET_BITS-1 -: 8];
        end
    end
`else
    always_comb begin
        payload_byte = 1'b1;
        last_byte    = (BYTE_W'(byte_idx + BYTE_W'(1)) == nbytes_q);
        tx_byte      = shreg[PACKET_BITS-1 -: 8];
    end
`endif

    always_comb begin
        state_next = state;
        uart_tx    = 1'b1;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_event) begin
`ifdef PKT_DUMP_HEADER_EN
                    state_next = START;
`else
                    state_next = (nbytes_in == '0) ? FIN : START;
`endif
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                uart_tx = tx_byte[bit_idx];
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = last_byte ? FIN : START;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            det_q       <= 1'b0;
            bit_tmr     <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            nbytes_q    <= '0;
            shreg       <= '0;
            dropped_cnt <= '0;
        end else begin
            state <= state_next;
            det_q <= packet_detected;

            // FIN still counts as busy, so an event on the done cycle is dropped.
            if (pkt_event && (state != IDLE) && (dropped_cnt != 8'hFF)) begin
                dropped_cnt <= dropped_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    bit_tmr  <= '0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    if (pkt_event) begin
                        shreg    <= packet_in;
                        nbytes_q <= nbytes_in;
                    end
                end
                START, DATA, STOP: begin
                    bit_tmr <= bit_end ? '0 : bit_tmr + DIV_W'(1);
                    if (bit_end) begin
                        // bit_idx wraps to 0 after bit 7, ready for the next byte.
                        if (state == DATA) begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                        if (state == STOP) begin
                            byte_idx <= byte_idx + BYTE_W'(1);
                            if (payload_byte) begin
                                shreg <= {shreg[PACKET_BITS-9:0], 8'h00};
                            end
                        end
                    end
                end
                default: begin
                    bit_tmr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ble_packet_uart_dump.sv
module tb_ble_packet_uart_dump;

    localparam int unsigned PB       = 368;
    localparam int unsigned LW       = 9;
    localparam int unsigned CD       = 4;
    localparam int unsigned BYTE_CYC = 10 * CD;
    localparam int unsigned MAXB     = 46;

    logic          clk = 1'b0;
    logic          rst;
    logic          packet_detected;
    logic [PB-1:0] packet_in;
    logic [LW-1:0] packet_len;
    logic          uart_tx;
    logic          busy;
    logic          done;
    logic [7:0]    dropped_cnt;

    always #5 clk = ~clk;

    ble_packet_uart_dump #(
        .PACKET_BITS(PB),
        .LEN_W      (LW),
        .CLK_DIV    (CD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .packet_detected(packet_detected),
        .packet_in      (packet_in),
        .packet_len     (packet_len),
        .uart_tx        (uart_tx),
        .busy           (busy),
        .done           (done),
        .dropped_cnt    (dropped_cnt)
    );

    typedef struct {
        int          len;
        logic [31:0] top;     // first four packet bytes; the rest follow a fixed pattern
        int          nbytes;  // hand-computed payload byte count
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    int         exp_drop = 0;
    logic [7:0] exp_line [0:47];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat_byte(input logic [31:0] top, input int k);
        if (k < 4) return top[31-8*k -: 8];
        return 8'(k * 7 + 3);
    endfunction

    function automatic logic [PB-1:0] make_pkt(input logic [31:0] top);
        logic [PB-1:0] p;
        p = '0;
        for (int k = 0; k < MAXB; k++) p[PB-1-8*k -: 8] = pat_byte(top, k);
        return p;
    endfunction

    // Launches one capture, checks every line cycle of the frame and the
    // done/busy timing. 'edges' extra rising edges (with scrambled inputs)
    // are injected from cycle 3; ev_on_done raises an event on the FIN cycle.
    task automatic run_frame(input int len, input logic [31:0] top, input int nbytes,
                             input int edges, input bit ev_on_done);
        logic [9:0] obs;
        logic [9:0] exp_frame;
        bit         bad;
        bit         ctl_err;
        int         n;
        n = 0;
`ifdef PKT_DUMP_HEADER_EN
        exp_line[0] = 8'hA5;
        exp_line[1] = 8'(nbytes);
        n = 2;
`endif
        for (int k = 0; k < nbytes; k++) begin
            exp_line[n] = pat_byte(top, k);
            n++;
        end

        @(negedge clk);
        packet_in       = make_pkt(top);
        packet_len      = LW'(len);
        packet_detected = 1'b1;
        @(negedge clk);  // first cycle after capture
        packet_detected = 1'b0;
        obs     = '0;
        bad     = 1'b0;
        ctl_err = 1'b0;
        if (n == 0) check("line idle on empty frame", 32'(uart_tx), 32'd1);

        for (int cyc = 1; cyc <= n * int'(BYTE_CYC); cyc++) begin
            int j, r, p, q;
            j = (cyc - 1) / int'(BYTE_CYC);
            r = (cyc - 1) % int'(BYTE_CYC);
            p = r / int'(CD);
            q = r % int'(CD);
            if (q == 0) obs[p] = uart_tx;
            else if (uart_tx !== obs[p]) bad = 1'b1;
            if (done !== 1'b0 || busy !== 1'b1) ctl_err = 1'b1;
            if (r == int'(BYTE_CYC) - 1) begin
                exp_frame = {1'b1, exp_line[j], 1'b0};
                check($sformatf("frame byte %0d (len %0d)", j, len),
                      {21'b0, bad, obs}, {22'b0, exp_frame});
                bad = 1'b0;
            end
            if (edges > 0 && cyc >= 3 && cyc <= 2 + 2 * edges) begin
                packet_detected = cyc[0];
                packet_in       = ~packet_in;
                packet_len      = ~packet_len;
            end
            @(negedge clk);
        end

        if (n > 0) check("busy held, no early done", 32'(ctl_err), 32'd0);
        check($sformatf("done pulse (len %0d)", len), 32'(done), 32'd1);
        check("busy during FIN", 32'(busy), 32'd1);
        exp_drop = exp_drop + edges;
        if (ev_on_done) begin
            packet_detected = 1'b1;
            exp_drop++;
        end
        if (exp_drop > 255) exp_drop = 255;
        @(negedge clk);
        check("done falls", 32'(done), 32'd0);
        check("busy falls", 32'(busy), 32'd0);
        check("line idle after frame", 32'(uart_tx), 32'd1);
        repeat (2) @(negedge clk);
        check("no capture after frame", 32'(busy), 32'd0);
        packet_detected = 1'b0;
        check("dropped_cnt", 32'(dropped_cnt), 32'(exp_drop));
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{16,  32'hA1B2_0000, 2};
        vecs[1] = '{500, 32'hDEAD_BEEF, 46};
        vecs[2] = '{9,   32'h8001_FFFF, 2};
        vecs[3] = '{0,   32'hFFFF_FFFF, 0};
        vecs[4] = '{24,  32'h1234_5678, 3};
        vecs[5] = '{368, 32'h0F1E_2D3C, 46};
        vecs[6] = '{1,   32'h8000_0000, 1};
        vecs[7] = '{8,   32'h5A00_0000, 1};

        rst             = 1'b1;
        packet_detected = 1'b0;
        packet_in       = '0;
        packet_len      = '0;
        repeat (3) @(negedge clk);
        check("reset uart_tx", 32'(uart_tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset dropped_cnt", 32'(dropped_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].len, vecs[i].top, vecs[i].nbytes, 0, 1'b0);
        end

        // Overrun: three edges while busy, frame content must not change.
        run_frame(16, 32'hA1B2_0000, 2, 3, 1'b0);
        // Saturation: 300 edges during a long frame.
        run_frame(368, 32'h3C3C_C3C3, 46, 300, 1'b0);
        // Event on the done cycle at saturation: stays at 255.
        run_frame(16, 32'hA1B2_0000, 2, 0, 1'b1);

        // Reset in the middle of a data bit that drives the line low.
        @(negedge clk);
        packet_in       = make_pkt(32'hA1B2_0000);
        packet_len      = LW'(16);
        packet_detected = 1'b1;
        @(negedge clk);
        packet_detected = 1'b0;
        check("start bit at capture+1", 32'(uart_tx), 32'd0);
        repeat (9) @(negedge clk);
        check("data bit1 low before reset", 32'(uart_tx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid-frame reset uart_tx", 32'(uart_tx), 32'd1);
        check("mid-frame reset busy", 32'(busy), 32'd0);
        check("mid-frame reset done", 32'(done), 32'd0);
        check("mid-frame reset dropped_cnt", 32'(dropped_cnt), 32'd0);
        exp_drop = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Event coinciding with done is dropped; then a clean frame follows.
        run_frame(16, 32'hA1B2_0000, 2, 0, 1'b1);
        run_frame(24, 32'h1234_5678, 3, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
